// File: rtl/pulse_encoder.sv
// pulse_encoder: serialises words MSB first as fixed-period return-to-zero pulses
// (short high = 0, long high = 1), ending each frame with a low latch interval.
module pulse_encoder #(
    parameter int DATA_WIDTH  = 8,
    parameter int CLK_DIV     = 5,
    parameter int BIT_TICKS   = 5,
    parameter int T0H_TICKS   = 2,
    parameter int T1H_TICKS   = 3,
    parameter int RESET_TICKS = 10
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    input  logic                  i_last,
    output logic                  o_ready,
    output logic                  o_line,
    output logic                  o_busy,
    output logic                  o_underrun
);
    localparam int MAXT = BIT_TICKS > RESET_TICKS ? BIT_TICKS : RESET_TICKS;
    localparam int TW   = $clog2(MAXT + 1);
    localparam int BW   = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
    localparam int DW   = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} state_t;

    state_t                state_q, state_d;
    logic [DW-1:0]         div_q, div_d;
    logic [TW-1:0]         tick_q, tick_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d, hold_q, hold_d;
    logic                  last_q, last_d, hlast_q, hlast_d, hvalid_q, hvalid_d;
    logic                  line_q, line_d, under_q, under_d;
    logic                  tick, period_end, last_bit, load, accept;
    logic [TW-1:0]         thigh;

    assign tick       = div_q == DW'(CLK_DIV - 1);
    assign thigh      = shift_q[DATA_WIDTH-1] ? TW'(T1H_TICKS) : TW'(T0H_TICKS);
    assign period_end = (state_q == LOW) && tick && (tick_q == TW'(BIT_TICKS - 1));
    assign last_bit   = bit_q == '0;
    assign accept     = i_valid && !hvalid_q;
    // A held word starts a frame from IDLE or continues one gaplessly at the end of a non-final word.
    assign load       = hvalid_q && ((state_q == IDLE) || (period_end && last_bit && !last_q));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= IDLE;
            div_q    <= '0;
            tick_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            last_q   <= 1'b0;
            hold_q   <= '0;
            hlast_q  <= 1'b0;
            hvalid_q <= 1'b0;
            line_q   <= 1'b0;
            under_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            tick_q   <= tick_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            last_q   <= last_d;
            hold_q   <= hold_d;
            hlast_q  <= hlast_d;
            hvalid_q <= hvalid_d;
            line_q   <= line_d;
            under_q  <= under_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        div_d    = tick ? '0 : div_q + 1'b1;
        tick_d   = tick_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        last_d   = last_q;
        under_d  = 1'b0;
        hvalid_d = accept | (hvalid_q & ~load);
        hold_d   = accept ? i_data : hold_q;
        hlast_d  = accept ? i_last : hlast_q;
        case (state_q)
            IDLE: div_d = '0;
            HIGH: if (tick) begin
                tick_d = tick_q + 1'b1;
                if (tick_q == thigh - 1'b1) state_d = LOW;
            end
            LOW: if (period_end) begin
                tick_d = '0;
                if (!last_bit) begin
                    state_d = HIGH;
                    shift_d = shift_q << 1;
                    bit_d   = bit_q - 1'b1;
                end else begin
                    state_d = LATCH;
                    under_d = !last_q;
                end
            end else if (tick) tick_d = tick_q + 1'b1;
            LATCH: if (tick) begin
                tick_d  = (tick_q == TW'(RESET_TICKS - 1)) ? '0 : tick_q + 1'b1;
                state_d = (tick_q == TW'(RESET_TICKS - 1)) ? IDLE : LATCH;
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            state_d = HIGH;
            shift_d = hold_q;
            last_d  = hlast_q;
            bit_d   = BW'(DATA_WIDTH - 1);
            tick_d  = '0;
            under_d = 1'b0;
        end
    end

    always_comb begin
        line_d     = state_q == HIGH;
        o_line     = line_q;
        o_ready    = !hvalid_q;
        o_busy     = state_q != IDLE;
        o_underrun = under_q;
    end
endmodule
